// File: rtl/dual_counter_sched_pkg.sv
// Shared definitions for the dual counter scheduler: channel state type,
// one-hot grant encodings and the default count width.
package dual_counter_sched_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CH0  = 2'b01;
  localparam logic [1:0] GNT_CH1  = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational from the
// request vector; only the "last granted" pointer is registered. Out of reset
// the pointer says ch1 was served last, so ch0 wins the first contention.
module rr_arb2
  import dual_counter_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // last_q = 1'b1 means ch1 held the incrementer most recently
  logic last_q;
  logic last_d;

  // Grant selection: a lone requester wins, contention goes to the one not served last
  always_comb begin
    gnt_o = GNT_NONE;
    case (req_i)
      2'b01:   gnt_o = GNT_CH0;
      2'b10:   gnt_o = GNT_CH1;
      2'b11:   gnt_o = last_q ? GNT_CH0 : GNT_CH1;
      default: gnt_o = GNT_NONE;
    endcase
  end

  // Pointer next-state: move only when a grant is actually issued
  always_comb begin
    last_d = last_q;
    if (gnt_o == GNT_CH0) begin
      last_d = 1'b0;
    end else if (gnt_o == GNT_CH1) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register with synchronous reset favouring ch0
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dual_counter_sched.sv
// Two 8-bit up-counter channels sharing a single incrementer. Each channel
// runs IDLE -> RUN -> DONE -> IDLE; rr_arb2 picks which RUN channel owns the
// incrementer each cycle.
// Optional feature macro: DUAL_COUNTER_SCHED_ABORT_EN adds abort0/abort1,
// which return a running channel to IDLE without a done pulse.
module dual_counter_sched
  import dual_counter_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start0,
  input  logic [WIDTH-1:0] target0,
  input  logic             start1,
  input  logic [WIDTH-1:0] target1,
`ifdef DUAL_COUNTER_SCHED_ABORT_EN
  input  logic             abort0,
  input  logic             abort1,
`endif
  output logic [WIDTH-1:0] count0,
  output logic [WIDTH-1:0] count1,
  output logic             busy0,
  output logic             busy1,
  output logic             done0,
  output logic             done1,
  output logic [1:0]       grant
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  ch_state_e        state_q  [2];
  ch_state_e        state_d  [2];
  logic [WIDTH-1:0] count_q  [2];
  logic [WIDTH-1:0] count_d  [2];
  logic [WIDTH-1:0] tgt_q    [2];
  logic [WIDTH-1:0] tgt_d    [2];
  logic [WIDTH-1:0] target_s [2];

  logic [1:0]       start_s;
  logic [1:0]       abort_s;
  logic [1:0]       req_s;
  logic [1:0]       gnt_s;
  logic [WIDTH-1:0] inc_in_s;
  logic [WIDTH-1:0] inc_out_s;

  assign start_s     = {start1, start0};
  assign target_s[0] = target0;
  assign target_s[1] = target1;

`ifdef DUAL_COUNTER_SCHED_ABORT_EN
  assign abort_s = {abort1, abort0};
`else
  assign abort_s = 2'b00;
`endif

  // Requests: a channel in RUN asks for the incrementer unless it is aborting
  always_comb begin
    req_s = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      req_s[ch] = (state_q[ch] == RUN) && !abort_s[ch];
    end
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (req_s),
    .gnt_o (gnt_s)
  );

  // Shared incrementer: operand is the count of whichever channel holds the grant
  always_comb begin
    inc_in_s = count_q[0];
    if (gnt_s == GNT_CH1) begin
      inc_in_s = count_q[1];
    end else begin
      inc_in_s = count_q[0];
    end
    inc_out_s = inc_in_s + ONE;
  end

  // Per-channel next-state, count and latched-target logic
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      count_d[ch] = count_q[ch];
      tgt_d[ch]   = tgt_q[ch];
      case (state_q[ch])
        IDLE: begin
          if (start_s[ch]) begin
            count_d[ch] = ZERO;
            tgt_d[ch]   = target_s[ch];
            if (target_s[ch] == ZERO) begin
              state_d[ch] = DONE;
            end else begin
              state_d[ch] = RUN;
            end
          end else begin
            state_d[ch] = IDLE;
          end
        end
        RUN: begin
          if (abort_s[ch]) begin
            state_d[ch] = IDLE;
          end else if (gnt_s[ch]) begin
            count_d[ch] = inc_out_s;
            if (inc_out_s == tgt_q[ch]) begin
              state_d[ch] = DONE;
            end else begin
              state_d[ch] = RUN;
            end
          end else begin
            state_d[ch] = RUN;
          end
        end
        DONE: begin
          state_d[ch] = IDLE;
        end
        default: begin
          state_d[ch] = IDLE;
        end
      endcase
    end
  end

  // Channel state, count and target registers with synchronous reset
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (reset) begin
        state_q[ch] <= IDLE;
        count_q[ch] <= ZERO;
        tgt_q[ch]   <= ZERO;
      end else begin
        state_q[ch] <= state_d[ch];
        count_q[ch] <= count_d[ch];
        tgt_q[ch]   <= tgt_d[ch];
      end
    end
  end

  assign count0 = count_q[0];
  assign count1 = count_q[1];
  assign busy0  = (state_q[0] == RUN);
  assign busy1  = (state_q[1] == RUN);
  assign done0  = (state_q[0] == DONE);
  assign done1  = (state_q[1] == DONE);
  assign grant  = gnt_s;

endmodule
